dropout_mask_gen: RTL and testbench
===================================

// Module: dropout_mask_gen
// PURPOSE
//  Consumes the free-running 32-bit pseudo-random word from the LFSR stage.
//  Turns it into LANES-wide keep/drop masks for the accelerator's dropout / stochastic-sparsity path.
//  Each lane is kept when its RBITS-bit random slice is below a programmable threshold.
//  Masks are delivered on a valid/ready stream; a job produces cfg_len masks.
// PARAMETERS
//  LANES  8   lanes per mask (bits of m_mask)
//  RBITS  8   random bits per lane comparison; 32 % RBITS == 0 required
//  WPM    ceil(LANES*RBITS/32), derived localparam: random words consumed per mask
// PORTS
//  clk       in   1          clock, all state on rising edge
//  rst       in   1          asynchronous, active-high reset
//  rnd_i     in   32         LFSR output; a new value every cycle
//  start     in   1          1-cycle job request; sampled only in IDLE
//  cfg_thr   in   RBITS+1    keep threshold; latched on accepted start
//  cfg_len   in   16         masks in job; latched on accepted start
//  busy      out  1          high from accepted start until done
//  m_valid   out  1          mask available
//  m_ready   in   1          consumer accepts mask
//  m_mask    out  LANES      bit i = 1 -> lane i kept
//  m_last    out  1          qualifies final mask of job
//  done      out  1          1-cycle pulse at job end
//  keep_cnt  out  32         kept lanes in accepted masks this job; saturates at 2^32-1
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; busy, m_valid, m_last, done = 0; m_mask = 0; keep_cnt = 0.
//  Counters and latched cfg are cleared by reset.
//  Lane rule: slice k of a word = rnd_i[k*RBITS +: RBITS]; keep = (slice < thr_q), unsigned compare.
//   thr_q = 0 drops all lanes; thr_q = 2^RBITS keeps all lanes.
//  Lane order: word 0 slice 0 -> lane 0, ascending; word w slice k -> lane w*(32/RBITS)+k.
//   Slices beyond lane LANES-1 in the last word are discarded.
//  FSM states and transitions:
//   IDLE: start=1 and cfg_len!=0 -> latch cfg, clear keep_cnt, busy=1 -> GATHER.
//         start=1 and cfg_len==0 -> keep_cnt cleared; done pulses next cycle; stay IDLE; no mask.
//   GATHER: sample rnd_i on each of the WPM edges after entry; word counter 0..WPM-1.
//         At edge WPM: mask register complete -> HOLD, m_valid=1.
//   HOLD: m_mask and m_last held stable while m_valid & !m_ready; rnd_i ignored.
//         On m_valid & m_ready: keep_cnt += popcount(m_mask) (saturating); remaining -= 1.
//          remaining was 1 -> IDLE, m_valid=0, busy=0, done=1 for one cycle.
//          otherwise -> GATHER, m_valid=0.
//  Latency: start sampled at edge E0 -> rnd_i sampled at edges E1..E_WPM -> m_valid high after E_WPM.
//  Throughput: one mask per WPM+1 cycles with m_ready held high. No overlap between HOLD and GATHER.
//  m_last = m_valid & (remaining == 1).
//  start while busy is ignored; cfg_thr / cfg_len changes during a job have no effect.
//  keep_cnt holds its value after done until the next accepted start.
//  Reset mid-job aborts immediately; the partial mask is lost; no done pulse is generated.
//  No combinational path from m_ready to m_valid or m_mask.
// TESTING (LANES=8, RBITS=8, WPM=2)
//  T1 thr=256, len=3, m_ready=1, LFSR attached
//     -> masks 0xFF,0xFF,0xFF every 3 cycles; m_last on 3rd; done 1 cycle; keep_cnt=24.
//  T2 thr=0, len=2 -> masks 0x00,0x00; keep_cnt=0; done pulse after 2nd handshake.
//  T3 rnd_i=0x807F1090 then 0x00FF7F80 on edges E1,E2; thr=0x80 -> m_mask=0xA6; keep_cnt=4.
//  T4 m_ready=0 for 5 cycles in HOLD while rnd_i toggles
//     -> m_valid, m_mask, m_last stable; accepted on m_ready=1.
//  T5 start with len=0 -> done pulse next cycle, m_valid never rises, busy stays 0.
//     start while busy -> ignored, job length unchanged.
//  T6 assert rst in HOLD of mask 2 of 4 -> all outputs 0 asynchronously.
//     New start, thr=256, len=1 -> one 0xFF mask with m_last.

Source files
------------

// File: rtl/dropout_mask_gen.sv
// Thresholds LANES random slices into a keep/drop mask; WPM+1 cycles/mask, valid after WPM rnd samples.
// Backpressure: the mask is held stable and rnd_i ignored while m_valid & !m_ready; no gather/hold overlap.
module dropout_mask_gen #(
    parameter int LANES = 8,
    parameter int RBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rnd_i,
    input  logic             start,
    input  logic [RBITS:0]   cfg_thr,
    input  logic [15:0]      cfg_len,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LANES-1:0] m_mask,
    output logic             m_last,
    output logic             done,
    output logic [31:0]      keep_cnt
);

    localparam int SPW = 32 / RBITS;
    localparam int WPM = (LANES * RBITS + 31) / 32;
    localparam int WCW = (WPM > 1) ? $clog2(WPM) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATHER,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [WCW-1:0]   wcnt_q;
    logic [RBITS:0]   thr_q;
    logic [15:0]      rem_q;
    logic [LANES-1:0] mask_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      keep_q;

    logic [SPW-1:0]   slice_keep;
    logic [LANES-1:0] mask_d;
    logic [31:0]      pop;
    logic [32:0]      keep_sum;
    logic [31:0]      keep_d;

    always_comb begin
        slice_keep = '0;
        for (int k = 0; k < SPW; k++) begin
            slice_keep[k] = ({1'b0, rnd_i[k*RBITS +: RBITS]} < thr_q);
        end
        // Only the lanes owned by the current word are updated; excess slices are dropped.
        mask_d = mask_q;
        for (int l = 0; l < LANES; l++) begin
            if ((l / SPW) == int'(wcnt_q)) begin
                mask_d[l] = slice_keep[l % SPW];
            end
        end
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + 32'(mask_q[l]);
        end
        keep_sum = {1'b0, keep_q} + {1'b0, pop};
        keep_d   = keep_sum[32] ? '1 : keep_sum[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            thr_q   <= '0;
            rem_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            keep_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        keep_q <= '0;
                        if (cfg_len != 16'd0) begin
                            thr_q   <= cfg_thr;
                            rem_q   <= cfg_len;
                            wcnt_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_GATHER;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_GATHER: begin
                    mask_q <= mask_d;
                    if (wcnt_q == WCW'(WPM - 1)) begin
                        wcnt_q  <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (rem_q == 16'd1);
                        state_q <= S_HOLD;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        keep_q  <= keep_d;
                        rem_q   <= rem_q - 16'd1;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (rem_q == 16'd1) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GATHER;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign m_valid  = valid_q;
    assign m_mask   = mask_q;
    assign m_last   = last_q;
    assign done     = done_q;
    assign keep_cnt = keep_q;

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Randomized bench for dropout_mask_gen: stimulus pushes expected masks, a negedge monitor pops on handshake.
module tb_dropout_mask_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rnd_i;
    logic        start;
    logic [8:0]  cfg_thr;
    logic [15:0] cfg_len;
    logic        busy;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_mask;
    logic        m_last;
    logic        done;
    logic [31:0] keep_cnt;

    typedef struct packed {
        logic [7:0] mask;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    dropout_mask_gen #(.LANES(8), .RBITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rnd_i    (rnd_i),
        .start    (start),
        .cfg_thr  (cfg_thr),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_mask   (m_mask),
        .m_last   (m_last),
        .done     (done),
        .keep_cnt (keep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Lane l is kept when random byte l of the two-word stream (word 0 first) is below thr.
    function automatic logic [7:0] ref_mask(input logic [63:0] words, input logic [8:0] thr);
        logic [7:0] m;
        int         slice;
        for (int l = 0; l < 8; l++) begin
            slice = int'(words[l*8 +: 8]);
            m[l]  = (slice < int'(thr));
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid mask=%h", m_mask);
            end else if (m_ready) begin
                exp_t e;
                e = sbq.pop_front();
                chk("mask", 32'(m_mask), 32'(e.mask));
                chk("last", 32'(m_last), 32'(e.last));
            end
        end
    end

    // Called and returns one time unit after a rising edge.
    task automatic run_job(input logic [8:0] thr, input int len, input bit rand_ready,
                           input int stall_idx, input int abort_idx, input bit fixed,
                           input bit poke_start);
        int          exp_keep;
        int          guard;
        bit          hs;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  em;
        exp_keep = 0;
        start    = 1'b1;
        cfg_thr  = thr;
        cfg_len  = 16'(len);
        rnd_i    = $urandom;
        m_ready  = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cfg_thr = 9'($urandom);
        cfg_len = 16'($urandom);
        if (len == 0) begin
            chk("len0_done", 32'(done), 32'd1);
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_keep", keep_cnt, 32'd0);
            @(posedge clk); #1;
            chk("len0_done_clr", 32'(done), 32'd0);
            chk("len0_valid", 32'(m_valid), 32'd0);
            return;
        end
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < len; i++) begin
            w0    = (fixed && i == 0) ? 32'h807F1090 : $urandom;
            rnd_i = w0;
            if (poke_start && i == 0) begin
                start   = 1'b1;
                cfg_len = 16'd7;
                cfg_thr = 9'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            w1    = (fixed && i == 0) ? 32'h00FF7F80 : $urandom;
            rnd_i = w1;
            chk("valid_gather", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
            em = ref_mask({w1, w0}, thr);
            sbq.push_back('{mask: em, last: (i == len - 1)});
            chk("valid_rise", 32'(m_valid), 32'd1);
            if (i == abort_idx) begin
                m_ready = 1'b0;
                rnd_i   = $urandom;
                #2 rst = 1'b1;
                #1;
                chk("abort_valid", 32'(m_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_mask", 32'(m_mask), 32'd0);
                chk("abort_last", 32'(m_last), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_keep", keep_cnt, 32'd0);
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                sbq.delete();
                return;
            end
            guard = 0;
            hs    = 1'b0;
            while (!hs && guard < 100) begin
                rnd_i = $urandom;
                if (i == stall_idx && guard < 5) begin
                    m_ready = 1'b0;
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_mask", 32'(m_mask), 32'(em));
                    chk("stall_last", 32'(m_last), 32'(i == len - 1));
                end else begin
                    m_ready = rand_ready ? 1'($urandom) : 1'b1;
                end
                hs = m_valid && m_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout mask_index=%0d", i);
                return;
            end
            exp_keep += $countones(em);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(m_valid), 32'd0);
        chk("keep_cnt", keep_cnt, 32'(exp_keep));
        @(posedge clk); #1;
        chk("done_clr", 32'(done), 32'd0);
        chk("keep_hold", keep_cnt, 32'(exp_keep));
    endtask

    initial begin
        rst     = 1'b1;
        rnd_i   = '0;
        start   = 1'b0;
        cfg_thr = '0;
        cfg_len = '0;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_mask", 32'(m_mask), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_keep", keep_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(9'd256, 3, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(9'd100, 0, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(9'd0,   2, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(9'h080, 1, 1'b0, -1, -1, 1'b1, 1'b0);
        chk("directed_keep", keep_cnt, 32'd4);
        run_job(9'($urandom_range(0, 256)), 3, 1'b0, 1, -1, 1'b0, 1'b0);
        run_job(9'd200, 4, 1'b1, -1, -1, 1'b0, 1'b1);
        run_job(9'd256, 4, 1'b0, -1, 1, 1'b0, 1'b0);
        run_job(9'd256, 1, 1'b0, -1, -1, 1'b0, 1'b0);
        repeat (8) begin
            run_job(9'($urandom_range(0, 256)), $urandom_range(1, 5), 1'b1, -1, -1, 1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
